// File: rtl/coin_start_seq.sv
// coin_start_seq: turns player start requests into a frame-timed coin-then-start pulse sequence.
// Optional COIN_SEQ_DIRECT_COIN_EN adds a coin_btn input ORed (registered) into coin.
module coin_start_seq #(
  parameter int COIN_FRAMES  = 4,
  parameter int GAP_FRAMES   = 6,
  parameter int START_FRAMES = 4,
  parameter int CNT_W        = 4
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic vblank,
  input  logic req1,
  input  logic req2,
`ifdef COIN_SEQ_DIRECT_COIN_EN
  input  logic coin_btn,
`endif
  output logic coin,
  output logic start1,
  output logic start2,
  output logic busy
);
  typedef enum logic [2:0] {IDLE, COIN_ON, COIN_GAP, START_ON, REL_WAIT} state_t;
  localparam logic [CNT_W-1:0] C_END = CNT_W'(COIN_FRAMES - 1);
  localparam logic [CNT_W-1:0] G_END = CNT_W'(GAP_FRAMES - 1);
  localparam logic [CNT_W-1:0] S_END = CNT_W'(START_FRAMES - 1);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, limit;
  logic [1:0] left_q, left_d;
  logic mode2_q, mode2_d;
  logic vblank_q, req1_q, req2_q, arm_q, coin_q, start1_q, start2_q, busy_q;
  logic tick, rise1, rise2, done;
  // arm_q suppresses a false edge when a request is already held as reset releases
  always_comb begin
    tick    = vblank & ~vblank_q;
    rise1   = req1 & ~req1_q & arm_q;
    rise2   = req2 & ~req2_q & arm_q;
    limit   = state_q == COIN_ON ? C_END : state_q == COIN_GAP ? G_END : S_END;
    done    = tick && cnt_q == limit;
    state_d = state_q;
    left_d  = left_q;
    mode2_d = mode2_q;
    cnt_d   = done ? '0 : tick ? cnt_q + 1'b1 : cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rise1 || rise2) begin
          state_d = COIN_ON;
          mode2_d = rise2;
          left_d  = rise2 ? 2'd2 : 2'd1;
        end
      end
      COIN_ON: if (done) begin
        state_d = COIN_GAP;
        left_d  = left_q - 2'd1;
      end
      COIN_GAP: if (done) state_d = left_q != 2'd0 ? COIN_ON : START_ON;
      START_ON: if (done) state_d = REL_WAIT;
      REL_WAIT: begin
        cnt_d = '0;
        if (!req1 && !req2) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      left_q   <= '0;
      mode2_q  <= 1'b0;
      vblank_q <= 1'b0;
      req1_q   <= 1'b0;
      req2_q   <= 1'b0;
      arm_q    <= 1'b0;
      coin_q   <= 1'b0;
      start1_q <= 1'b0;
      start2_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      left_q   <= left_d;
      mode2_q  <= mode2_d;
      vblank_q <= vblank;
      req1_q   <= req1;
      req2_q   <= req2;
      arm_q    <= 1'b1;
      coin_q   <= state_d == COIN_ON;
      start1_q <= state_d == START_ON && !mode2_d;
      start2_q <= state_d == START_ON && mode2_d;
      busy_q   <= state_d != IDLE;
    end
`ifdef COIN_SEQ_DIRECT_COIN_EN
  logic coin_btn_q;
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) coin_btn_q <= 1'b0;
    else coin_btn_q <= coin_btn;
  assign coin = coin_q | coin_btn_q;
`else
  assign coin = coin_q;
`endif
  assign start1 = start1_q;
  assign start2 = start2_q;
  assign busy   = busy_q;
endmodule

// File: tb/tb_coin_start_seq.sv
// tb_coin_start_seq: directed checks of coin/start pulse timing against a 100-cycle vblank.
module tb_coin_start_seq;
  logic clk_sys, reset_n, vblank, req1, req2;
  logic coin, start1, start2, busy;
`ifdef COIN_SEQ_DIRECT_COIN_EN
  logic coin_btn;
`endif
  int n_chk, n_pass, fc, t0, nover;
  int first [4], last [4], ncyc [4], npulse [4];
  logic prev [4];
  logic [3:0] outs;
  bit vb_en;

  coin_start_seq dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .vblank(vblank), .req1(req1), .req2(req2),
`ifdef COIN_SEQ_DIRECT_COIN_EN
    .coin_btn(coin_btn),
`endif
    .coin(coin), .start1(start1), .start2(start2), .busy(busy)
  );

  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // index 0 coin, 1 start1, 2 start2, 3 busy; vblank rises when fc%100 == 50
  task automatic step();
    @(negedge clk_sys);
    fc++;
    outs = {busy, start2, start1, coin};
    for (int i = 0; i < 4; i++)
      if (outs[i] === 1'b1) begin
        if (!prev[i]) npulse[i]++;
        if (ncyc[i] == 0) first[i] = fc;
        last[i] = fc;
        ncyc[i]++;
        prev[i] = 1'b1;
      end else prev[i] = 1'b0;
    if (coin === 1'b1 && (start1 === 1'b1 || start2 === 1'b1)) nover++;
    vblank = vb_en && (fc % 100) >= 50 && (fc % 100) < 55;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clr();
    for (int i = 0; i < 4; i++) begin
      first[i] = 0; last[i] = 0; ncyc[i] = 0; npulse[i] = 0;
    end
    nover = 0;
  endtask

  task automatic align();
    step();
    while (fc % 100 != 0) step();
    clr();
    t0 = fc;
  endtask

  task automatic check_1p(input string tag);
    chk({tag, " coin_first"}, first[0] - t0, 1);
    chk({tag, " coin_last"}, last[0] - t0, 350);
    chk({tag, " coin_pulses"}, npulse[0], 1);
    chk({tag, " start1_first"}, first[1] - t0, 951);
    chk({tag, " start1_cycles"}, ncyc[1], 400);
    chk({tag, " start2_cycles"}, ncyc[2], 0);
    chk({tag, " busy_first"}, first[3] - t0, 1);
    chk({tag, " overlap"}, nover, 0);
  endtask

  task automatic check_2p(input string tag);
    chk({tag, " coin_first"}, first[0] - t0, 1);
    chk({tag, " coin_last"}, last[0] - t0, 1350);
    chk({tag, " coin_cycles"}, ncyc[0], 750);
    chk({tag, " coin_pulses"}, npulse[0], 2);
    chk({tag, " start2_first"}, first[2] - t0, 1951);
    chk({tag, " start2_last"}, last[2] - t0, 2350);
    chk({tag, " start1_cycles"}, ncyc[1], 0);
    chk({tag, " busy_last"}, last[3] - t0, 2351);
    chk({tag, " overlap"}, nover, 0);
  endtask

  initial begin
    n_chk = 0; n_pass = 0; fc = 0;
    reset_n = 1'b0; vblank = 1'b0; req1 = 1'b1; req2 = 1'b0; vb_en = 1'b1;
    for (int i = 0; i < 4; i++) prev[i] = 1'b0;
`ifdef COIN_SEQ_DIRECT_COIN_EN
    coin_btn = 1'b0;
`endif
    clr();
    run(300);
    chk("rst coin", ncyc[0], 0);
    chk("rst start1", ncyc[1], 0);
    chk("rst start2", ncyc[2], 0);
    chk("rst busy", ncyc[3], 0);
    reset_n = 1'b1;
    clr();
    run(300);
    chk("rel held coin", ncyc[0], 0);
    chk("rel held busy", ncyc[3], 0);
    req1 = 1'b0;
    run(5);

    align();
    req1 = 1'b1;
    run(300);
    req1 = 1'b0;
    run(1100);
    check_1p("1p");
    chk("1p busy_last", last[3] - t0, 1351);

    align();
    req2 = 1'b1;
    run(300);
    req2 = 1'b0;
    run(2200);
    check_2p("2p");

    align();
    req1 = 1'b1; req2 = 1'b1;
    run(300);
    req1 = 1'b0; req2 = 1'b0;
    run(2200);
    check_2p("both");

    align();
    req1 = 1'b1;
    run(400);
    req1 = 1'b0;
    run(10);
    req1 = 1'b1;
    run(1100);
    check_1p("hold");
    chk("hold busy_in_relwait", int'(busy), 1);
    req1 = 1'b0;
    run(5);
    chk("hold busy_last", last[3] - t0, 1510);
    run(300);
    chk("hold busy_after", int'(busy), 0);
    chk("hold no_retrigger", npulse[0], 1);

    align();
    req1 = 1'b1;
    run(1000);
    chk("midrst start1_before", int'(start1), 1);
    reset_n = 1'b0;
    #1;
    chk("midrst start1_async", int'(start1), 0);
    chk("midrst busy_async", int'(busy), 0);
    req1 = 1'b0;
    run(5);
    reset_n = 1'b1;
    run(5);
    chk("midrst idle", int'(busy), 0);
    align();
    req1 = 1'b1;
    run(300);
    req1 = 1'b0;
    run(1100);
    check_1p("fresh");
    chk("fresh busy_last", last[3] - t0, 1351);

`ifdef COIN_SEQ_DIRECT_COIN_EN
    align();
    coin_btn = 1'b1;
    run(10);
    coin_btn = 1'b0;
    run(10);
    chk("btn coin_first", first[0] - t0, 1);
    chk("btn coin_cycles", ncyc[0], 10);
    chk("btn busy", ncyc[3], 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
